// File: rtl/perf_counter_master.sv
// Avalon-MM master that brackets sections of the four-section performance
// counter slave: local commands become go/stop/global-reset writes, and a
// snapshot command reads one section's 64-bit time (tear-checked) and events.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op, cmd_section   0=start 1=stop 2=global reset 3=snapshot; section 0..3
//   avm_*                 Avalon-MM master towards the counter slave
//   snap_*                snapshot result; snap_valid is a one-cycle pulse
module perf_counter_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_section,
  output logic [3:0]  avm_address,
  output logic        avm_write,
  output logic        avm_begintransfer,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        snap_valid,
  output logic [1:0]  snap_section,
  output logic [63:0] snap_time,
  output logic [31:0] snap_events,
  output logic        snap_torn
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned RETRY_W = 3;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(READ_LATENCY);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [1:0]         OP_START  = 2'd0;
  localparam logic [1:0]         OP_GRST   = 2'd2;
  localparam logic [1:0]         OP_SNAP   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_EV, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [1:0]           sec_q, sec_d;
  logic [31:0]          hi1_q, hi1_d;
  logic [31:0]          lo_q, lo_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 torn_q, torn_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic [3:0]           avm_address_q, avm_address_d;
  logic                 avm_write_q, avm_write_d;
  logic                 avm_begin_q, avm_begin_d;
  logic                 avm_read_q, avm_read_d;
  logic [31:0]          avm_writedata_q, avm_writedata_d;
  logic                 snap_valid_q, snap_valid_d;
  logic [1:0]           snap_section_q, snap_section_d;
  logic [63:0]          snap_time_q, snap_time_d;
  logic [31:0]          snap_events_q, snap_events_d;
  logic                 snap_torn_q, snap_torn_d;

  logic                 accept;
  logic                 rd_next;

  assign accept = cmd_valid && cmd_ready_q;

  // Next state, datapath captures, and output values decoded from the next state
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    sec_d           = sec_q;
    hi1_d           = hi1_q;
    lo_d            = lo_q;
    retry_d         = retry_q;
    torn_d          = torn_q;
    snap_valid_d    = 1'b0;
    snap_section_d  = snap_section_q;
    snap_time_d     = snap_time_q;
    snap_events_d   = snap_events_q;
    snap_torn_d     = snap_torn_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          sec_d   = cmd_section;
          retry_d = '0;
          torn_d  = 1'b0;
          cnt_d   = '0;
          state_d = (cmd_op == OP_SNAP) ? S_RD_HI1 : S_WR;
        end
      end
      S_WR:   state_d = S_IDLE;
      S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_EV: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          unique case (state_q)
            S_RD_HI1: begin
              hi1_d   = avm_readdata;
              state_d = S_RD_LO;
            end
            S_RD_LO: begin
              lo_d    = avm_readdata;
              state_d = S_RD_HI2;
            end
            S_RD_HI2: begin
              // High word moved since hi1: the low word may belong to either epoch
              if (avm_readdata == hi1_q) begin
                state_d = S_RD_EV;
              end else if (retry_q < RETRY_MAX) begin
                hi1_d   = avm_readdata;
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_RD_LO;
              end else begin
                torn_d  = 1'b1;
                state_d = S_RD_EV;
              end
            end
            default: begin
              state_d        = S_DONE;
              snap_valid_d   = 1'b1;
              snap_section_d = sec_q;
              snap_time_d    = {hi1_q, lo_q};
              snap_events_d  = avm_readdata;
              snap_torn_d    = torn_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_next         = (state_d == S_RD_HI1) || (state_d == S_RD_LO) ||
                      (state_d == S_RD_HI2) || (state_d == S_RD_EV);
    cmd_ready_d     = (state_d == S_IDLE);
    avm_write_d     = (state_d == S_WR);
    avm_read_d      = rd_next;
    avm_begin_d     = (state_d == S_WR) || (rd_next && (cnt_d == '0));
    avm_writedata_d = ((state_d == S_WR) && (op_d == OP_GRST)) ? 32'd1 : 32'd0;

    unique case (state_d)
      S_WR:     avm_address_d = (op_d == OP_GRST) ? 4'd0
                                : {sec_d, 1'b0, (op_d == OP_START)};
      S_RD_HI1: avm_address_d = {sec_d, 2'd1};
      S_RD_HI2: avm_address_d = {sec_d, 2'd1};
      S_RD_LO:  avm_address_d = {sec_d, 2'd0};
      S_RD_EV:  avm_address_d = {sec_d, 2'd2};
      default:  avm_address_d = 4'd0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      op_q            <= '0;
      sec_q           <= '0;
      hi1_q           <= '0;
      lo_q            <= '0;
      retry_q         <= '0;
      torn_q          <= 1'b0;
      cmd_ready_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_write_q     <= 1'b0;
      avm_begin_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_writedata_q <= '0;
      snap_valid_q    <= 1'b0;
      snap_section_q  <= '0;
      snap_time_q     <= '0;
      snap_events_q   <= '0;
      snap_torn_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      sec_q           <= sec_d;
      hi1_q           <= hi1_d;
      lo_q            <= lo_d;
      retry_q         <= retry_d;
      torn_q          <= torn_d;
      cmd_ready_q     <= cmd_ready_d;
      avm_address_q   <= avm_address_d;
      avm_write_q     <= avm_write_d;
      avm_begin_q     <= avm_begin_d;
      avm_read_q      <= avm_read_d;
      avm_writedata_q <= avm_writedata_d;
      snap_valid_q    <= snap_valid_d;
      snap_section_q  <= snap_section_d;
      snap_time_q     <= snap_time_d;
      snap_events_q   <= snap_events_d;
      snap_torn_q     <= snap_torn_d;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign avm_address       = avm_address_q;
  assign avm_write         = avm_write_q;
  assign avm_begintransfer = avm_begin_q;
  assign avm_read          = avm_read_q;
  assign avm_writedata     = avm_writedata_q;
  assign snap_valid        = snap_valid_q;
  assign snap_section      = snap_section_q;
  assign snap_time         = snap_time_q;
  assign snap_events       = snap_events_q;
  assign snap_torn         = snap_torn_q;

endmodule

// File: tb/tb_perf_counter_master.sv
// Self-checking bench for perf_counter_master: directed and randomized
// commands against a scripted counter-slave model and a reference model of
// the tear-free snapshot algorithm.
module tb_perf_counter_master;

  localparam int RL = 1;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_section;
  logic [3:0]  avm_address;
  logic        avm_write;
  logic        avm_begintransfer;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        snap_valid;
  logic [1:0]  snap_section;
  logic [63:0] snap_time;
  logic [31:0] snap_events;
  logic        snap_torn;

  perf_counter_master #(.READ_LATENCY(RL), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_section(cmd_section),
    .avm_address(avm_address), .avm_write(avm_write), .avm_begintransfer(avm_begintransfer),
    .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .snap_valid(snap_valid), .snap_section(snap_section), .snap_time(snap_time),
    .snap_events(snap_events), .snap_torn(snap_torn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int snap_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scripted slave: each read transfer pops the next scripted value for its word;
  // an exhausted script keeps returning its last value. Registered readdata (latency 1).
  logic [31:0] hi_q[$];
  logic [31:0] lo_q[$];
  logic [31:0] ev_val = '0;
  logic [31:0] hi_last = '0;
  logic [31:0] lo_last = '0;
  logic [3:0]  rd_addrs[$];

  initial avm_readdata = '0;
  always @(posedge clk) begin
    if (avm_read && avm_begintransfer) begin
      rd_addrs.push_back(avm_address);
      case (avm_address[1:0])
        2'd0: begin
          if (lo_q.size() > 0) lo_last = lo_q.pop_front();
          avm_readdata <= lo_last;
        end
        2'd1: begin
          if (hi_q.size() > 0) hi_last = hi_q.pop_front();
          avm_readdata <= hi_last;
        end
        default: avm_readdata <= ev_val;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("rw_exclusive", 64'(avm_read & avm_write), 64'd0);
    if (snap_valid) snap_pulses++;
  end

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return q[q.size()-1];
  endfunction

  task automatic do_wr(input logic [1:0] op, input logic [1:0] sec);
    logic [3:0]  exp_addr;
    exp_addr = (op == 2'd2) ? 4'd0 : 4'(sec * 4 + ((op == 2'd0) ? 1 : 0));
    @(negedge clk);
    chk("wr_ready_before", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_section = sec;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("wr_write",  64'(avm_write), 64'd1);
    chk("wr_begin",  64'(avm_begintransfer), 64'd1);
    chk("wr_read",   64'(avm_read), 64'd0);
    chk("wr_addr",   64'(avm_address), 64'(exp_addr));
    chk("wr_data",   64'(avm_writedata), (op == 2'd2) ? 64'd1 : 64'd0);
    chk("wr_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("wr_write_done", 64'(avm_write), 64'd0);
    chk("wr_ready_back", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_snap(input logic [1:0] sec, input logic [31:0] his[$],
                         input logic [31:0] los[$], input logic [31:0] ev);
    logic [31:0] hi1, hi2, lo;
    logic [63:0] exp_addrs, got_addrs;
    logic [3:0]  base;
    int hi_i, lo_i, retries, v_cyc, r_cyc, pulses0;
    bit torn;
    // Reference: read hi, lo, hi; retry lo/hi while the high word keeps moving
    base = 4'(sec * 4);
    hi1 = pick(his, 0); lo = pick(los, 0); hi_i = 1; lo_i = 1; retries = 0; torn = 0;
    exp_addrs = {52'd0, base + 4'd1, base, base + 4'd1};
    forever begin
      hi2 = pick(his, hi_i); hi_i++;
      if (hi2 == hi1) break;
      if (retries < MR) begin
        retries++; hi1 = hi2; lo = pick(los, lo_i); lo_i++;
        exp_addrs = {exp_addrs[55:0], base, base + 4'd1};
      end else begin
        torn = 1; break;
      end
    end
    exp_addrs = {exp_addrs[59:0], base + 4'd2};

    hi_q = his; lo_q = los; ev_val = ev; rd_addrs.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_section = sec;
    pulses0 = snap_pulses;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    v_cyc = -1; r_cyc = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (snap_valid && v_cyc < 0) v_cyc = cyc;
      if (cmd_ready) begin r_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    got_addrs = '0;
    foreach (rd_addrs[i]) got_addrs = {got_addrs[59:0], rd_addrs[i]};
    chk("snap_valid_cycle", 64'(v_cyc), 64'(9 + 2 * (RL + 1) * retries));
    chk("snap_ready_cycle", 64'(r_cyc), 64'(10 + 2 * (RL + 1) * retries));
    chk("snap_pulse_count", 64'(snap_pulses - pulses0), 64'd1);
    chk("snap_read_addrs",  got_addrs, exp_addrs);
    chk("snap_time",    snap_time, {hi1, lo});
    chk("snap_events",  64'(snap_events), 64'(ev));
    chk("snap_torn",    64'(snap_torn), 64'(torn));
    chk("snap_section", 64'(snap_section), 64'(sec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] his[$];
    logic [31:0] los[$];
    logic [31:0] h;
    logic [63:0] held;
    int pulses0;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_section = '0;
    #12;
    chk("rst_ready",  64'(cmd_ready), 64'd0);
    chk("rst_write",  64'(avm_write), 64'd0);
    chk("rst_read",   64'(avm_read), 64'd0);
    chk("rst_begin",  64'(avm_begintransfer), 64'd0);
    chk("rst_addr",   64'(avm_address), 64'd0);
    chk("rst_snapv",  64'(snap_valid), 64'd0);
    chk("rst_time",   snap_time, 64'd0);
    chk("rst_torn",   64'(snap_torn), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", 64'(cmd_ready), 64'd1);

    // Directed writes: start sec 1, stop sec 3, global reset with section 3
    do_wr(2'd0, 2'd1);
    do_wr(2'd1, 2'd3);
    do_wr(2'd2, 2'd3);

    // Stable snapshot of section 2
    his = '{32'd7, 32'd7}; los = '{32'h0000_1234};
    do_snap(2'd2, his, los, 32'd42);
    chk("dir_time_a", snap_time, 64'h0000_0007_0000_1234);

    // High word ticks 3 -> 4 around a low word near wrap
    his = '{32'd3, 32'd4, 32'd4}; los = '{32'hFFFF_FFFE, 32'h0000_0001};
    do_snap(2'd0, his, los, 32'd5);
    chk("dir_time_b", snap_time, 64'h0000_0004_0000_0001);

    // High word changes on every read: retries exhaust, torn result
    his = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    los = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    do_snap(2'd3, his, los, 32'd99);
    chk("dir_torn", 64'(snap_torn), 64'd1);

    // Snapshot data holds across a later write command
    held = snap_time;
    do_wr(2'd0, 2'd2);
    chk("snap_hold", snap_time, held);

    // Back-to-back commands with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_section = 2'd2;
    @(posedge clk); #1;
    chk("b2b_first_addr", 64'(avm_address), 64'd8);
    @(negedge clk); cmd_op = 2'd0; cmd_section = 2'd3;
    @(posedge clk); #1;
    chk("b2b_gap_write", 64'(avm_write), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_second_write", 64'(avm_write), 64'd1);
    chk("b2b_second_addr", 64'(avm_address), 64'd13);
    @(posedge clk); #1;

    // Randomized mix of writes and snapshots
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_wr(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
      end else begin
        his.delete(); los.delete();
        h = $urandom;
        his.push_back(h);
        for (int i = 0; i < 10; i++) begin
          if ($urandom_range(0, 2) == 0) h = h + 32'd1;
          his.push_back(h);
          los.push_back($urandom);
        end
        do_snap(2'($urandom_range(0, 3)), his, los, $urandom);
      end
    end

    // Reset in the middle of RD_LO abandons the snapshot
    his = '{32'd9, 32'd9}; los = '{32'd77};
    hi_q = his; lo_q = los;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_section = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_in_rd_lo", 64'(avm_address), 64'd4);
    pulses0 = snap_pulses;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_read",  64'(avm_read), 64'd0);
    chk("mid_rst_begin", 64'(avm_begintransfer), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_ready_after", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      chk("mid_no_bus", 64'({avm_read, avm_write}), 64'd0);
      @(posedge clk); #1;
    end
    chk("mid_no_snap", 64'(snap_pulses - pulses0), 64'd0);
    do_wr(2'd0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
